// File: rtl/cpu_pkg.sv
// Shared constants and types for the fetch stage.
package cpu_pkg;
   localparam int               WORD_W       = 32;
   localparam logic [WORD_W-1:0] PC_STEP      = 32'd4;
   localparam logic [WORD_W-1:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [WORD_W-1:0] NOP_INSTR    = 32'h0000_0000;
   localparam logic [WORD_W-1:0] TRAP_PC_DEF  = 32'h0000_0080;

   typedef enum logic [1:0] {
      PC_SEQ,
      PC_HOLD,
      PC_TARGET,
      PC_TRAP
   } pc_sel_e;
endpackage

// File: rtl/pc_reg.sv
// Program counter register with next-PC selection (sequential / hold / redirect / trap).
// Trap path exists only when MISALIGN_TRAP_EN is defined.
module pc_reg
   import cpu_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEF,
   parameter logic [WORD_W-1:0] TRAP_PC  = TRAP_PC_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              branch_taken,
   input  logic [WORD_W-1:0] branch_target,
`ifdef MISALIGN_TRAP_EN
   output logic              trap_take,
`endif
   output logic [WORD_W-1:0] pc
);

   logic [WORD_W-1:0] pc_q, pc_d;
   pc_sel_e           sel;

   always_comb begin
      sel = PC_SEQ;
      if (branch_taken) begin
`ifdef MISALIGN_TRAP_EN
         sel = (branch_target[1:0] != 2'b00) ? PC_TRAP : PC_TARGET;
`else
         sel = PC_TARGET;
`endif
      end else if (stall) begin
         sel = PC_HOLD;
      end
   end

   // Redirect targets are forced word-aligned so PC[1:0] never leaves 2'b00.
   always_comb begin
      pc_d = pc_q + PC_STEP;
      unique case (sel)
         PC_SEQ:    pc_d = pc_q + PC_STEP;
         PC_HOLD:   pc_d = pc_q;
         PC_TARGET: pc_d = branch_target & ~32'h0000_0003;
         PC_TRAP:   pc_d = TRAP_PC;
         default:   pc_d = pc_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) pc_q <= RESET_PC;
      else     pc_q <= pc_d;
   end

   assign pc = pc_q;
`ifdef MISALIGN_TRAP_EN
   assign trap_take = (sel == PC_TRAP);
`endif

endmodule

// File: rtl/etapa_fetch.sv
// Instruction-fetch stage: PC drives Read_addres, returned word is latched into IF/ID.
// Optional misaligned-redirect trap enabled by defining MISALIGN_TRAP_EN.
module etapa_fetch
   import cpu_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEF,
   parameter logic [WORD_W-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR,
   parameter logic [WORD_W-1:0] TRAP_PC   = TRAP_PC_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              branch_taken,
   input  logic [WORD_W-1:0] branch_target,
   output logic [WORD_W-1:0] Read_addres,
   input  logic [WORD_W-1:0] instruccion,
   output logic [WORD_W-1:0] if_id_pc,
   output logic [WORD_W-1:0] if_id_pc4,
   output logic [WORD_W-1:0] if_id_instr,
`ifdef MISALIGN_TRAP_EN
   output logic              misalign_err,
`endif
   output logic              if_id_valid
);

   logic [WORD_W-1:0] pc;
   logic [WORD_W-1:0] if_id_pc_q, if_id_pc_d;
   logic [WORD_W-1:0] if_id_pc4_q, if_id_pc4_d;
   logic [WORD_W-1:0] if_id_instr_q, if_id_instr_d;
   logic              if_id_valid_q, if_id_valid_d;

`ifdef MISALIGN_TRAP_EN
   logic trap_take;
   logic misalign_err_q, misalign_err_d;
`endif

   pc_reg #(
      .RESET_PC (RESET_PC),
      .TRAP_PC  (TRAP_PC)
   ) u_pc_reg (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
`ifdef MISALIGN_TRAP_EN
      .trap_take     (trap_take),
`endif
      .pc            (pc)
   );

   assign Read_addres = pc;

   // A redirect kills the wrong-path word; a bubble keeps the last pc/pc4.
   always_comb begin
      if_id_pc_d    = if_id_pc_q;
      if_id_pc4_d   = if_id_pc4_q;
      if_id_instr_d = if_id_instr_q;
      if_id_valid_d = if_id_valid_q;
      if (branch_taken || flush) begin
         if_id_instr_d = NOP_INSTR;
         if_id_valid_d = 1'b0;
      end else if (!stall) begin
         if_id_pc_d    = pc;
         if_id_pc4_d   = pc + PC_STEP;
         if_id_instr_d = instruccion;
         if_id_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         if_id_pc_q    <= '0;
         if_id_pc4_q   <= '0;
         if_id_instr_q <= NOP_INSTR;
         if_id_valid_q <= 1'b0;
      end else begin
         if_id_pc_q    <= if_id_pc_d;
         if_id_pc4_q   <= if_id_pc4_d;
         if_id_instr_q <= if_id_instr_d;
         if_id_valid_q <= if_id_valid_d;
      end
   end

`ifdef MISALIGN_TRAP_EN
   assign misalign_err_d = trap_take;

   always_ff @(posedge clk) begin
      if (rst) misalign_err_q <= 1'b0;
      else     misalign_err_q <= misalign_err_d;
   end

   assign misalign_err = misalign_err_q;
`endif

   assign if_id_pc    = if_id_pc_q;
   assign if_id_pc4   = if_id_pc4_q;
   assign if_id_instr = if_id_instr_q;
   assign if_id_valid = if_id_valid_q;

endmodule

// File: tb/tb_etapa_fetch.sv
// Directed bench for etapa_fetch with a combinational instruction memory model.
// Define MISALIGN_TRAP_EN to exercise the trap build.
module tb_etapa_fetch;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst, stall, flush, branch_taken;
   logic [31:0] branch_target;
   logic [31:0] Read_addres, instruccion;
   logic [31:0] if_id_pc, if_id_pc4, if_id_instr;
   logic        if_id_valid;
`ifdef MISALIGN_TRAP_EN
   logic        misalign_err;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   // Instruction memory: content is a fixed scramble of the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   assign instruccion = mem_word(Read_addres);

   etapa_fetch dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .flush         (flush),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .Read_addres   (Read_addres),
      .instruccion   (instruccion),
      .if_id_pc      (if_id_pc),
      .if_id_pc4     (if_id_pc4),
      .if_id_instr   (if_id_instr),
`ifdef MISALIGN_TRAP_EN
      .misalign_err  (misalign_err),
`endif
      .if_id_valid   (if_id_valid)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_ifid(input string tag, input logic [31:0] pc, input logic vld,
                             input logic [31:0] instr);
      check({tag, ".pc"},    if_id_pc,    pc);
      check({tag, ".pc4"},   if_id_pc4,   pc + 32'd4);
      check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, vld});
      check({tag, ".instr"}, if_id_instr, instr);
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = '0;
      step(); step();
      check("rst.ra",    Read_addres, 32'h0);
      check("rst.pc",    if_id_pc,    32'h0);
      check("rst.pc4",   if_id_pc4,   32'h0);
      check("rst.instr", if_id_instr, 32'h0);
      check("rst.valid", {31'd0, if_id_valid}, 32'd0);
`ifdef MISALIGN_TRAP_EN
      check("rst.merr",  {31'd0, misalign_err}, 32'd0);
`endif

      // sequential fetch
      rst = 1'b0;
      step();
      check("seq1.ra", Read_addres, 32'h4);
      check_ifid("seq1", 32'h0, 1'b1, mem_word(32'h0));
      step();
      check("seq2.ra", Read_addres, 32'h8);
      check_ifid("seq2", 32'h4, 1'b1, mem_word(32'h4));

      // stall at PC=8 for 3 cycles
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall.ra", Read_addres, 32'h8);
         check_ifid("stall", 32'h4, 1'b1, mem_word(32'h4));
      end
      stall = 1'b0;
      step();
      check("resume.ra", Read_addres, 32'hC);
      check_ifid("resume8", 32'h8, 1'b1, mem_word(32'h8));
      step();
      check("resumeC.ra", Read_addres, 32'h10);
      check_ifid("resumeC", 32'hC, 1'b1, mem_word(32'hC));

      // flush at PC=0x10
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush.ra", Read_addres, 32'h14);
      check_ifid("flush", 32'hC, 1'b0, 32'h0);
      step();
      check("postflush.ra", Read_addres, 32'h18);
      check_ifid("postflush", 32'h14, 1'b1, mem_word(32'h14));

      // branch with simultaneous stall
      branch_taken = 1'b1; branch_target = 32'h40; stall = 1'b1;
      step();
      branch_taken = 1'b0; stall = 1'b0;
      check("br.ra", Read_addres, 32'h40);
      check_ifid("br", 32'h14, 1'b0, 32'h0);
`ifdef MISALIGN_TRAP_EN
      check("br.merr", {31'd0, misalign_err}, 32'd0);
`endif
      step();
      check("br2.ra", Read_addres, 32'h44);
      check_ifid("br2", 32'h40, 1'b1, mem_word(32'h40));

      // wrap at top of address space
      branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
      step();
      branch_taken = 1'b0;
      check("wrap0.ra", Read_addres, 32'hFFFF_FFFC);
      step();
      check("wrap1.ra", Read_addres, 32'h0);
      check("wrap1.pc",  if_id_pc,  32'hFFFF_FFFC);
      check("wrap1.pc4", if_id_pc4, 32'h0);
      step();
      step();
      check("pre_rst.ra", Read_addres, 32'h8);

      // reset during stall
      stall = 1'b1;
      step();
      check("stall2.ra", Read_addres, 32'h8);
      rst = 1'b1;
      step();
      check("rst2.ra",    Read_addres, 32'h0);
      check("rst2.valid", {31'd0, if_id_valid}, 32'd0);
      check("rst2.pc",    if_id_pc, 32'h0);
      rst = 1'b0; stall = 1'b0;
      step();
      check("rst2r.ra", Read_addres, 32'h4);
      check_ifid("rst2r", 32'h0, 1'b1, mem_word(32'h0));

      // misaligned redirect
      branch_taken = 1'b1; branch_target = 32'h42;
      step();
      branch_taken = 1'b0;
`ifdef MISALIGN_TRAP_EN
      check("mis.ra",   Read_addres, 32'h80);
      check("mis.merr", {31'd0, misalign_err}, 32'd1);
      check("mis.valid", {31'd0, if_id_valid}, 32'd0);
      step();
      check("mis2.ra",   Read_addres, 32'h84);
      check("mis2.merr", {31'd0, misalign_err}, 32'd0);
      check_ifid("mis2", 32'h80, 1'b1, mem_word(32'h80));
`else
      check("mis.ra",    Read_addres, 32'h40);
      check("mis.valid", {31'd0, if_id_valid}, 32'd0);
      step();
      check("mis2.ra", Read_addres, 32'h44);
      check_ifid("mis2", 32'h40, 1'b1, mem_word(32'h40));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
